// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared states, number codes and timing constants for the phrase sequencer
// Purpose: the FSM state encoding, the map's special number codes and the
//          sample-rate-derived inter-word gap.
// Ports:   none (package).
package audio_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_MAP_WAIT = 3'd1;
  localparam state_t S_CHECK    = 3'd2;
  localparam state_t S_PLAY     = 3'd3;
  localparam state_t S_GAP      = 3'd4;
  localparam state_t S_FINISH   = 3'd5;

  // Follow-on codes returned by the number-to-address map.
  localparam logic [7:0] NUM_END = 8'd0;
  localparam logic [7:0] NUM_BPM = 8'd230;

  // Silence between words: 100 ms of audio at the player's sample rate.
  localparam int SAMPLE_RATE_HZ     = 27000;
  localparam int GAP_MS             = 100;
  localparam int DEFAULT_GAP_CYCLES = SAMPLE_RATE_HZ * GAP_MS / 1000;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/audio_phrase_sequencer_if.sv
// rtl/audio_phrase_sequencer_if.sv - requester, map and player signals of the phrase sequencer
// Purpose: bundles every non-clock signal of the sequencer.
// Ports:   master = sequencer view (drives status, map_number, play_*),
//          slave  = environment view (requester, map, player).
interface audio_phrase_sequencer_if #(
  parameter int ADR_W = 32
);
  logic             speak_req;
  logic [7:0]       speak_number;
  logic             abort;
  logic             busy;
  logic             done;
  logic             err;
  logic [7:0]       map_number;
  logic [ADR_W-1:0] map_start_adr;
  logic [ADR_W-1:0] map_stop_adr;
  logic [7:0]       map_out_number;
  logic             play_start;
  logic [ADR_W-1:0] play_start_adr;
  logic [ADR_W-1:0] play_stop_adr;
  logic             play_abort;
  logic             play_done;

  modport master (
    input  speak_req, speak_number, abort,
    input  map_start_adr, map_stop_adr, map_out_number, play_done,
    output busy, done, err, map_number,
    output play_start, play_start_adr, play_stop_adr, play_abort
  );

  modport slave (
    output speak_req, speak_number, abort,
    output map_start_adr, map_stop_adr, map_out_number, play_done,
    input  busy, done, err, map_number,
    input  play_start, play_start_adr, play_stop_adr, play_abort
  );
endinterface

// File: rtl/audio_delay_counter.sv
// rtl/audio_delay_counter.sv - loadable down-counter with zero flag
// Purpose: counts a loaded value down to zero and holds there.
// Ports:   clk, reset_n (async active-low), load/load_value (load wins over dec),
//          dec (decrement while non-zero), zero (count is zero).
module audio_delay_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/audio_phrase_sequencer.sv
// rtl/audio_phrase_sequencer.sv - speaks a number phrase by chaining map lookups and segment playbacks
// Purpose: loads a number into the map, waits out the map latency, plays the
//          returned [start, stop) segment and follows the map's follow-on code
//          until end-of-phrase.
// Ports:   clk, reset_n (async active-low), bus (master view of
//          audio_phrase_sequencer_if: request/status, map, player).
module audio_phrase_sequencer
  import audio_pkg::*;
#(
  parameter int ADR_W      = 32,
  parameter int MAP_LAT    = 1,
  parameter int GAP_CYCLES = audio_pkg::DEFAULT_GAP_CYCLES,
  parameter int MAX_SEG    = 4
) (
  input logic                       clk,
  input logic                       reset_n,
  audio_phrase_sequencer_if.master  bus
);

  localparam int SEG_W = cnt_width(MAX_SEG);
  localparam int LAT_W = cnt_width(MAP_LAT);
  localparam int GAP_W = cnt_width(GAP_CYCLES);

  // MAP_WAIT lasts MAP_LAT+1 cycles: load MAP_LAT and leave on zero.
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MAP_LAT);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [SEG_W-1:0] SEG_MAX  = SEG_W'(MAX_SEG);

  state_t           state;
  logic             busy;
  logic             done;
  logic             err;
  logic             play_start;
  logic             play_abort;
  logic [7:0]       map_number;
  logic [7:0]       next_num;
  logic [ADR_W-1:0] play_start_adr;
  logic [ADR_W-1:0] play_stop_adr;
  logic [SEG_W-1:0] seg_cnt;

  logic stop_req;
  logic next_word;
  logic lat_load;
  logic lat_dec;
  logic lat_zero;
  logic gap_load;
  logic gap_dec;
  logic gap_zero;

  // abort outranks everything, including a play_done in the same cycle.
  always_comb begin
    stop_req  = bus.abort && (state != S_IDLE);
    next_word = (state == S_PLAY) && bus.play_done && (next_num != NUM_END) && !stop_req;
    lat_load  = ((state == S_IDLE) && bus.speak_req)
              || (next_word && (GAP_CYCLES == 0))
              || ((state == S_GAP) && gap_zero && !stop_req);
    lat_dec   = (state == S_MAP_WAIT);
    gap_load  = next_word && (GAP_CYCLES > 0);
    gap_dec   = (state == S_GAP);
  end

  audio_delay_counter #(.W(LAT_W)) u_lat_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (lat_load),
    .load_value (LAT_LOAD),
    .dec        (lat_dec),
    .zero       (lat_zero)
  );

  audio_delay_counter #(.W(GAP_W)) u_gap_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (gap_load),
    .load_value (GAP_LOAD),
    .dec        (gap_dec),
    .zero       (gap_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      play_start     <= 1'b0;
      play_abort     <= 1'b0;
      map_number     <= 8'd0;
      next_num       <= 8'd0;
      play_start_adr <= '0;
      play_stop_adr  <= '0;
      seg_cnt        <= '0;
    end else begin
      done       <= 1'b0;
      err        <= 1'b0;
      play_start <= 1'b0;
      play_abort <= 1'b0;
      if (stop_req) begin
        state      <= S_IDLE;
        busy       <= 1'b0;
        play_abort <= (state == S_PLAY);
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.speak_req) begin
              map_number <= bus.speak_number;
              seg_cnt    <= '0;
              busy       <= 1'b1;
              state      <= S_MAP_WAIT;
            end
          end
          S_MAP_WAIT: begin
            if (lat_zero) state <= S_CHECK;
          end
          S_CHECK: begin
            // Equal addresses (including the map's 0/0 default) mean nothing to say.
            if (bus.map_start_adr == bus.map_stop_adr) begin
              done  <= 1'b1;
              err   <= (seg_cnt == '0);
              state <= S_FINISH;
            end else if (seg_cnt == SEG_MAX) begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= S_FINISH;
            end else begin
              play_start_adr <= bus.map_start_adr;
              play_stop_adr  <= bus.map_stop_adr;
              next_num       <= bus.map_out_number;
              seg_cnt        <= seg_cnt + SEG_W'(1);
              play_start     <= 1'b1;
              state          <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (bus.play_done) begin
              if (next_num == NUM_END) begin
                done  <= 1'b1;
                state <= S_FINISH;
              end else begin
                map_number <= next_num;
                state      <= (GAP_CYCLES > 0) ? S_GAP : S_MAP_WAIT;
              end
            end
          end
          S_GAP: begin
            if (gap_zero) state <= S_MAP_WAIT;
          end
          S_FINISH: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.err            = err;
  assign bus.map_number     = map_number;
  assign bus.play_start     = play_start;
  assign bus.play_start_adr = play_start_adr;
  assign bus.play_stop_adr  = play_stop_adr;
  assign bus.play_abort     = play_abort;

endmodule
